// File: rtl/bbox_pkg.sv
// Shared types and helpers for the per-player bounding-box tracker.
package bbox_pkg;
    localparam int COORD_W     = 11;
    localparam int NUM_PLAYERS = 2;
    localparam int CNT_W       = 16;

    typedef struct packed {
        logic [COORD_W-1:0] left;
        logic [COORD_W-1:0] right;
        logic [COORD_W-1:0] up;
        logic [COORD_W-1:0] down;
    } box_t;

    typedef enum logic [1:0] {CLS_NONE, CLS_P0, CLS_P1} pix_class_t;

    typedef struct packed {
        logic [COORD_W-1:0] min_x;
        logic [COORD_W-1:0] max_x;
        logic [COORD_W-1:0] min_y;
        logic [COORD_W-1:0] max_y;
        logic [CNT_W-1:0]   cnt;
    } acc_t;

    localparam logic [COORD_W-1:0] MIN_EMPTY = '1;
    localparam logic [COORD_W-1:0] MAX_EMPTY = '0;

    function automatic acc_t acc_empty();
        acc_t a;
        a.min_x = MIN_EMPTY;
        a.max_x = MAX_EMPTY;
        a.min_y = MIN_EMPTY;
        a.max_y = MAX_EMPTY;
        a.cnt   = '0;
        return a;
    endfunction

    function automatic acc_t acc_merge(acc_t a, logic [COORD_W-1:0] x, logic [COORD_W-1:0] y);
        acc_t m;
        m = a;
        if (x < a.min_x) m.min_x = x;
        if (x > a.max_x) m.max_x = x;
        if (y < a.min_y) m.min_y = y;
        if (y > a.max_y) m.max_y = y;
        if (a.cnt != '1) m.cnt = a.cnt + 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/bbox_pixel_classifier.sv
// Stage 1: colour-dominance classification, registered with x/y and frame_end.
module bbox_pixel_classifier
    import bbox_pkg::*;
#(
    parameter int COLOR_THR  = 128,
    parameter int DOM_MARGIN = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_pix_valid,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [7:0]         i_r,
    input  logic [7:0]         i_g,
    input  logic [7:0]         i_b,
    input  logic               i_frame_end,
    output pix_class_t         o_cls,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_frame_end
);
    logic [8:0] r9, b9, r_m, g_m, b_m;
    logic       is_red, is_blue;
    pix_class_t cls_n;

    // 9-bit sums so channel + margin can never wrap
    always_comb begin
        r9  = {1'b0, i_r};
        b9  = {1'b0, i_b};
        r_m = {1'b0, i_r} + 9'(DOM_MARGIN);
        g_m = {1'b0, i_g} + 9'(DOM_MARGIN);
        b_m = {1'b0, i_b} + 9'(DOM_MARGIN);
        is_red  = (r9 >= 9'(COLOR_THR)) && (r9 >= g_m) && (r9 >= b_m);
        is_blue = (b9 >= 9'(COLOR_THR)) && (b9 >= g_m) && (b9 >= r_m);
        cls_n = CLS_NONE;
        if (i_pix_valid && i_enable) begin
            if (is_red)       cls_n = CLS_P0;
            else if (is_blue) cls_n = CLS_P1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cls       <= CLS_NONE;
            o_x         <= '0;
            o_y         <= '0;
            o_frame_end <= 1'b0;
        end else begin
            o_cls       <= cls_n;
            o_x         <= i_x;
            o_y         <= i_y;
            o_frame_end <= i_frame_end;
        end
    end
endmodule

// File: rtl/bbox_tracker.sv
// Per-player min/max box accumulation with frame close and miss-hold parking.
module bbox_tracker
    import bbox_pkg::*;
#(
    parameter int MIN_PIXELS = 64,
    parameter int MISS_HOLD  = 4,
    parameter int PARK_VAL   = 300,
    parameter int COLOR_THR  = 128,
    parameter int DOM_MARGIN = 32
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_enable,
    input  logic                                  i_pix_valid,
    input  logic [COORD_W-1:0]                    i_x,
    input  logic [COORD_W-1:0]                    i_y,
    input  logic [7:0]                            i_r,
    input  logic [7:0]                            i_g,
    input  logic [7:0]                            i_b,
    input  logic                                  i_frame_end,
    output logic [NUM_PLAYERS-1:0][COORD_W-1:0]   o_left,
    output logic [NUM_PLAYERS-1:0][COORD_W-1:0]   o_right,
    output logic [NUM_PLAYERS-1:0][COORD_W-1:0]   o_up,
    output logic [NUM_PLAYERS-1:0][COORD_W-1:0]   o_down,
    output logic [NUM_PLAYERS-1:0]                o_found,
    output logic                                  o_predict_valid
);
    localparam int MISS_W = $clog2(MISS_HOLD + 1);
    localparam logic [COORD_W-1:0] PARK = COORD_W'(PARK_VAL);

    pix_class_t         s1_cls;
    logic [COORD_W-1:0] s1_x, s1_y;
    logic               s1_fe;

    bbox_pixel_classifier #(
        .COLOR_THR  (COLOR_THR),
        .DOM_MARGIN (DOM_MARGIN)
    ) u_cls (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_enable    (i_enable),
        .i_pix_valid (i_pix_valid),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_r         (i_r),
        .i_g         (i_g),
        .i_b         (i_b),
        .i_frame_end (i_frame_end),
        .o_cls       (s1_cls),
        .o_x         (s1_x),
        .o_y         (s1_y),
        .o_frame_end (s1_fe)
    );

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        localparam pix_class_t MY_CLS = (p == 0) ? CLS_P0 : CLS_P1;
        acc_t              acc_q, acc_n;
        box_t              box_q;
        logic              found_q;
        logic [MISS_W-1:0] miss_q, miss_inc;

        // The pixel in stage 1 alongside frame_end belongs to the closing frame
        always_comb begin
            acc_n    = (s1_cls == MY_CLS) ? acc_merge(acc_q, s1_x, s1_y) : acc_q;
            miss_inc = (miss_q >= MISS_W'(MISS_HOLD)) ? MISS_W'(MISS_HOLD) : miss_q + 1'b1;
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                acc_q   <= acc_empty();
                box_q   <= '{PARK, PARK, PARK, PARK};
                found_q <= 1'b0;
                miss_q  <= MISS_W'(MISS_HOLD);
            end else if (s1_fe) begin
                acc_q <= acc_empty();
                if (acc_n.cnt >= CNT_W'(MIN_PIXELS)) begin
                    box_q   <= '{acc_n.min_x, acc_n.max_x, acc_n.min_y, acc_n.max_y};
                    found_q <= 1'b1;
                    miss_q  <= '0;
                end else begin
                    found_q <= 1'b0;
                    miss_q  <= miss_inc;
                    if (miss_inc >= MISS_W'(MISS_HOLD)) box_q <= '{PARK, PARK, PARK, PARK};
                end
            end else begin
                acc_q <= acc_n;
            end
        end

        assign o_left[p]  = box_q.left;
        assign o_right[p] = box_q.right;
        assign o_up[p]    = box_q.up;
        assign o_down[p]  = box_q.down;
        assign o_found[p] = found_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_predict_valid <= 1'b0;
        else          o_predict_valid <= s1_fe;
    end
endmodule

// File: tb/tb_bbox_tracker.sv
// Randomized scoreboard bench for bbox_tracker against a frame-level reference model.
module tb_bbox_tracker;
    localparam int CW = 11;
    localparam int PARK = 300;
    localparam int MINPIX = 64;
    localparam int HOLD = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic en = 1'b1, pv = 1'b0, fe = 1'b0;
    logic [CW-1:0] x = '0, y = '0;
    logic [7:0] r = '0, g = '0, b = '0;
    logic [1:0][CW-1:0] o_left, o_right, o_up, o_down;
    logic [1:0] o_found;
    logic o_pv;

    bbox_tracker dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_pix_valid(pv),
        .i_x(x), .i_y(y), .i_r(r), .i_g(g), .i_b(b), .i_frame_end(fe),
        .o_left(o_left), .o_right(o_right), .o_up(o_up), .o_down(o_down),
        .o_found(o_found), .o_predict_valid(o_pv)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0, total = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    typedef struct packed {
        logic [1:0][CW-1:0] l, rr, u, d;
        logic [1:0]         found;
        int                 cyc;
    } exp_t;
    exp_t sbq[$];

    // Reference model: per-frame extents and counts per player
    int m_minx[2], m_maxx[2], m_miny[2], m_maxy[2], m_cnt[2], m_miss[2];
    int m_box[2][4];
    bit m_found[2];

    function automatic void model_reset();
        for (int p = 0; p < 2; p++) begin
            m_minx[p] = 1 << 20; m_maxx[p] = -1; m_miny[p] = 1 << 20; m_maxy[p] = -1;
            m_cnt[p] = 0; m_miss[p] = HOLD; m_found[p] = 0;
            for (int k = 0; k < 4; k++) m_box[p][k] = PARK;
        end
    endfunction

    function automatic int classify(int rv, int gv, int bv);
        if (rv >= 128 && rv - gv >= 32 && rv - bv >= 32) return 0;
        if (bv >= 128 && bv - gv >= 32 && bv - rv >= 32) return 1;
        return -1;
    endfunction

    function automatic void model_pix(int px, int py, int rv, int gv, int bv);
        int p;
        p = classify(rv, gv, bv);
        if (p < 0) return;
        if (px < m_minx[p]) m_minx[p] = px;
        if (px > m_maxx[p]) m_maxx[p] = px;
        if (py < m_miny[p]) m_miny[p] = py;
        if (py > m_maxy[p]) m_maxy[p] = py;
        if (m_cnt[p] < 65535) m_cnt[p]++;
    endfunction

    function automatic void model_close(int at);
        exp_t e;
        for (int p = 0; p < 2; p++) begin
            if (m_cnt[p] >= MINPIX) begin
                m_box[p][0] = m_minx[p]; m_box[p][1] = m_maxx[p];
                m_box[p][2] = m_miny[p]; m_box[p][3] = m_maxy[p];
                m_found[p] = 1; m_miss[p] = 0;
            end else begin
                m_found[p] = 0;
                m_miss[p] = (m_miss[p] + 1 > HOLD) ? HOLD : m_miss[p] + 1;
                if (m_miss[p] >= HOLD) for (int k = 0; k < 4; k++) m_box[p][k] = PARK;
            end
            e.l[p] = m_box[p][0][CW-1:0]; e.rr[p] = m_box[p][1][CW-1:0];
            e.u[p] = m_box[p][2][CW-1:0]; e.d[p] = m_box[p][3][CW-1:0];
            e.found[p] = m_found[p];
            m_minx[p] = 1 << 20; m_maxx[p] = -1; m_miny[p] = 1 << 20; m_maxy[p] = -1;
            m_cnt[p] = 0;
        end
        e.cyc = at;
        sbq.push_back(e);
    endfunction

    // Drive one cycle of inputs and advance the model in step
    task automatic drive(bit v, int px, int py, int rv, int gv, int bv, bit f, bit e_n = 1'b1);
        @(posedge clk); #1;
        pv = v; x = CW'(px); y = CW'(py); r = 8'(rv); g = 8'(gv); b = 8'(bv); fe = f; en = e_n;
        if (v && e_n) model_pix(px, py, rv, gv, bv);
        if (f) model_close(cyc + 2);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic square(int x0, int y0, int w, int h, int rv, int gv, int bv);
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++) drive(1, x0 + i, y0 + j, rv, gv, bv, 0);
    endtask

    // Monitor: pops expected records whenever the DUT announces a new box set
    always @(negedge clk) begin
        if (rst_n) begin
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                total++;
                $display("FAIL missing_pulse: no predict_valid at cycle %0d (now %0d)", sbq[0].cyc, cyc);
                void'(sbq.pop_front());
            end
            if (o_pv) begin
                if (sbq.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_pulse: predict_valid at cycle %0d with nothing pending", cyc);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("latency", 64'(cyc), 64'(e.cyc));
                    chk("found", 64'(o_found), 64'(e.found));
                    chk("left", 64'(o_left), 64'(e.l));
                    chk("right", 64'(o_right), 64'(e.rr));
                    chk("up", 64'(o_up), 64'(e.u));
                    chk("down", 64'(o_down), 64'(e.d));
                end
            end
        end
    end

    task automatic check_parked(string tag);
        chk({tag, "_left"},  64'(o_left),  {2{CW'(PARK)}});
        chk({tag, "_right"}, 64'(o_right), {2{CW'(PARK)}});
        chk({tag, "_up"},    64'(o_up),    {2{CW'(PARK)}});
        chk({tag, "_down"},  64'(o_down),  {2{CW'(PARK)}});
        chk({tag, "_found"}, 64'(o_found), 64'(0));
        chk({tag, "_pv"},    64'(o_pv),    64'(0));
    endtask

    initial begin
        model_reset();
        #12;
        check_parked("reset");
        rst_n = 1'b1;
        idle(2);

        // empty frame
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // red square
        square(100, 50, 10, 10, 255, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // margin failure and threshold failure
        for (int i = 0; i < 200; i++) drive(1, i, 10, 200, 180, 0, 0);
        for (int i = 0; i < 200; i++) drive(1, i, 20, 100, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // detect, then four empty frames (two back-to-back)
        square(300, 200, 8, 9, 250, 10, 20);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(3);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // both players, with enable toggled off for a stray red pixel
        square(400, 300, 9, 8, 10, 20, 240);
        square(20, 30, 8, 8, 200, 50, 60);
        drive(1, 630, 470, 255, 0, 0, 0, 1'b0);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // last pixel coincident with frame end; next pixel starts frame k+1
        square(560, 100, 8, 8, 255, 0, 0);
        drive(1, 639, 110, 255, 0, 0, 1);
        drive(1, 5, 5, 255, 0, 0, 0);
        square(200, 200, 10, 7, 255, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(40, 260);
            for (int i = 0; i < n; i++) begin
                int kind, rv, gv, bv;
                bit last;
                kind = $urandom_range(0, 3);
                rv = $urandom_range(0, 255); gv = $urandom_range(0, 255); bv = $urandom_range(0, 255);
                if (kind == 0) begin rv = $urandom_range(160, 255); gv = $urandom_range(0, 140); bv = $urandom_range(0, 140); end
                if (kind == 1) begin bv = $urandom_range(160, 255); gv = $urandom_range(0, 140); rv = $urandom_range(0, 140); end
                last = (i == n - 1) && ($urandom_range(0, 1) == 1);
                drive($urandom_range(0, 7) != 0, $urandom_range(0, 639), $urandom_range(0, 479),
                      rv, gv, bv, last, $urandom_range(0, 15) != 0);
                if (i == n - 1 && !last) drive(0, 0, 0, 0, 0, 0, 1);
            end
            idle($urandom_range(0, 3));
        end
        idle(4);

        // reset mid-frame with a partial red accumulation
        square(50, 60, 10, 7, 255, 0, 0);
        @(posedge clk); #2;
        pv = 1'b0;
        rst_n = 1'b0;
        #1;
        check_parked("midreset");
        model_reset();
        sbq.delete();
        #10;
        rst_n = 1'b1;
        idle(2);
        drive(0, 0, 0, 0, 0, 0, 1);
        idle(5);

        chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
